trigger_handling_v3: RTL

//  Per-channel delay-aligned L4 coincidence and T1 generator, successor to the v2 handler.
//  - Delays each L4 trigger by a programmable amount and gathers aligned channels in a

---
 rtl/trigger_handling_v3_pkg.sv | 16 +
 rtl/trigger_handling_v3_trig_delay_line.sv | 43 ++++
 rtl/trigger_handling_v3.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/trigger_handling_v3_pkg.sv
// Shared constants for the v3 trigger handler: default channel count and
// field widths, plus the FSM state encodings used by the top level.
package trigger_handling_v3_pkg;

    localparam int SCAL_NUM_L4 = 5;
    localparam int DELAY_BITS  = 4;
    localparam int PRETRG_BITS = 9;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GATHER  = 2'd1;
    localparam logic [1:0] ST_DECIDE  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

endpackage

// File: rtl/trigger_handling_v3_trig_delay_line.sv
// Per-channel programmable delay for the {level, new} pair of one L4 channel.
// The input is injected at the slot chosen by the delay and then shifts toward
// slot 0, which is the output. A delay change therefore only affects bits
// entering from now on; bits already in flight keep their original timing.
// Output appears exactly delay+1 clocks after the input is presented.
module trigger_handling_v3_trig_delay_line #(
    parameter int DELAY_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DELAY_BITS-1:0] delay,
    input  logic                  new_in,
    input  logic                  lvl_in,
    output logic                  new_out,
    output logic                  lvl_out
);
    import trigger_handling_v3_pkg::*;

    localparam int DEPTH = 2 ** DELAY_BITS;

    // Two bits per slot: [1] level, [0] new strobe; slot 0 in bits [1:0].
    logic [2*DEPTH-1:0] sr;
    logic [2*DEPTH-1:0] nxt;

    // Shift one slot toward the output and merge the new sample at the delay slot.
    always_comb begin
        nxt = {2'b00, sr[2*DEPTH-1:2]};
        nxt[{delay, 1'b0} +: 2] = nxt[{delay, 1'b0} +: 2] | {lvl_in, new_in};
    end

    // Shift register storage, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= nxt;
        end
    end

    assign new_out = sr[0];
    assign lvl_out = sr[1];

endmodule

// File: rtl/trigger_handling_v3.sv
// Delay-aligned L4 coincidence and T1 generator.
// Each channel is delayed by its own programmable amount, aligned arrivals are
// gathered over a coincidence window, and a decision issues T1 with the largest
// pretrigger offset of the matched set, followed by a holdoff.
// Optional feature macro: TRIG_MULTIPLICITY_EN (adds min_mult_i and a minimum
// matched-channel count for a decision to fire).
// fsm_state exposes the controller state for observation.
module trigger_handling_v3 #(
    parameter int NUM_L4      = trigger_handling_v3_pkg::SCAL_NUM_L4,
    parameter int DELAY_BITS  = trigger_handling_v3_pkg::DELAY_BITS,
    parameter int PRETRG_BITS = trigger_handling_v3_pkg::PRETRG_BITS,
    parameter int WINDOW_BITS = 4,
    parameter int HOLDOFF     = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_L4*PRETRG_BITS-1:0]   pretrigger_vector_i,
    input  logic [NUM_L4*DELAY_BITS-1:0]    delay_vector_i,
    input  logic [WINDOW_BITS-1:0]          window_i,
    input  logic [NUM_L4-1:0]               l4_i,
    input  logic [NUM_L4-1:0]               l4_new_i,
    input  logic                            T1_mask_i,
    input  logic                            disable_i,
    input  logic                            disable_ce_i,
`ifdef TRIG_MULTIPLICITY_EN
    input  logic [$clog2(NUM_L4+1)-1:0]     min_mult_i,
`endif
    output logic [NUM_L4-1:0]               l4_matched_o,
    output logic [NUM_L4-1:0]               l4_new_o,
    output logic                            T1_o,
    output logic                            T1_scaler_o,
    output logic [PRETRG_BITS-1:0]          T1_offset_o,
    output logic                            busy_o,
    output trigger_handling_v3_pkg::state_t fsm_state
);
    import trigger_handling_v3_pkg::*;

    localparam int HO_W = $clog2(HOLDOFF + 2);

    logic [NUM_L4-1:0]      arr;
    logic [NUM_L4-1:0]      lvl;
    state_t                 state;
    logic                   dis;
    logic [NUM_L4-1:0]      acc;
    logic [NUM_L4-1:0]      matched_q;
    logic [WINDOW_BITS-1:0] win_cnt;
    logic [HO_W-1:0]        ho_cnt;
    logic [PRETRG_BITS-1:0] max_pt;
    logic                   mult_ok;

    for (genvar k = 0; k < NUM_L4; k++) begin : g_dl
        trigger_handling_v3_trig_delay_line #(
            .DELAY_BITS(DELAY_BITS)
        ) u_dl (
            .clk     (clk_i),
            .rst     (rst_i),
            .delay   (delay_vector_i[k*DELAY_BITS +: DELAY_BITS]),
            .new_in  (l4_new_i[k]),
            .lvl_in  (l4_i[k]),
            .new_out (arr[k]),
            .lvl_out (lvl[k])
        );
    end

    // Largest pretrigger among the matched channels; an empty or all-zero set gives 0.
    always_comb begin
        max_pt = '0;
        for (int k = 0; k < NUM_L4; k++) begin
            if (matched_q[k] && (pretrigger_vector_i[k*PRETRG_BITS +: PRETRG_BITS] > max_pt)) begin
                max_pt = pretrigger_vector_i[k*PRETRG_BITS +: PRETRG_BITS];
            end
        end
    end

`ifdef TRIG_MULTIPLICITY_EN
    localparam int MW = $clog2(NUM_L4 + 1);
    logic [MW-1:0] mult_cnt;
    logic [MW-1:0] mult_need;

    // Count matched channels against the programmed minimum; 0 acts as 1.
    always_comb begin
        mult_cnt = '0;
        for (int k = 0; k < NUM_L4; k++) begin
            mult_cnt = mult_cnt + MW'(matched_q[k]);
        end
        mult_need = (min_mult_i == '0) ? MW'(1) : min_mult_i;
        mult_ok   = (mult_cnt >= mult_need);
    end
`else
    // A gathered set always holds at least the opening arrival, so it always fires.
    assign mult_ok = 1'b1;
`endif

    // Disable flag, coincidence FSM and registered trigger outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            dis          <= 1'b0;
            acc          <= '0;
            matched_q    <= '0;
            win_cnt      <= '0;
            ho_cnt       <= '0;
            l4_matched_o <= '0;
            l4_new_o     <= '0;
            T1_o         <= 1'b0;
            T1_scaler_o  <= 1'b0;
            T1_offset_o  <= '0;
        end else begin
            if (disable_ce_i) begin
                dis <= disable_i;
            end
            T1_o        <= 1'b0;
            T1_scaler_o <= 1'b0;
            l4_new_o    <= '0;
            case (state)
                ST_IDLE: begin
                    if ((arr != '0) && !dis) begin
                        state   <= ST_GATHER;
                        acc     <= arr;
                        win_cnt <= (window_i == '0) ? WINDOW_BITS'(1) : window_i;
                    end
                end
                ST_GATHER: begin
                    if (dis) begin
                        state <= ST_IDLE;
                    end else if (win_cnt == WINDOW_BITS'(1)) begin
                        matched_q <= acc | arr | lvl;
                        state     <= ST_DECIDE;
                    end else begin
                        acc     <= acc | arr;
                        win_cnt <= win_cnt - WINDOW_BITS'(1);
                    end
                end
                ST_DECIDE: begin
                    if (mult_ok) begin
                        T1_scaler_o  <= 1'b1;
                        T1_o         <= ~T1_mask_i;
                        l4_new_o     <= matched_q;
                        l4_matched_o <= matched_q;
                        T1_offset_o  <= max_pt;
                        if (HOLDOFF == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state  <= ST_HOLDOFF;
                            ho_cnt <= HO_W'(HOLDOFF);
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HOLDOFF: begin
                    if (ho_cnt == HO_W'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        ho_cnt <= ho_cnt - HO_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o    = (state == ST_GATHER) || (state == ST_HOLDOFF);
    assign fsm_state = state;

endmodule
